axi_ifetch_master: RTL and testbench
====================================

Name: axi_ifetch_master

Overview:
- Single-outstanding AXI4 read master that fetches one 32-bit instruction per transaction for the current pc.
- Sits between the fetch stage (pc in, instr/instr_valid out) and the instruction-memory AXI read channels (AR, R) of a 64-bit data bus.
- Write channels are not implemented.

Parameters:
- AXI_ID, 4'h0, constant ARID value.
- EBREAK_INSTR, 32'h00100073, substitute instruction used by the optional error trap.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- pc  in  64  fetch address; byte address, 4-byte aligned
- instr  out  32  fetched instruction; valid when instr_valid=1
- instr_valid  out  1  one-cycle pulse per completed fetch
- ARID  out  4  =AXI_ID
- ARADDR  out  64  registered copy of pc
- ARLEN  out  8  =0 (single beat)
- ARSIZE  out  3  =3'b010 (4 bytes)
- ARBURST  out  2  =2'b01 (INCR)
- ARLOCK  out  1  =0
- ARCACHE  out  4  =4'b0000
- ARPORT  out  3  AXI ARPROT; =3'b100 (instruction, secure, unprivileged)
- ARQOS  out  4  =0
- ARREGION  out  4  =0
- ARVALID  out  1  address valid
- ARREADY  in  1  address ready
- RID  in  4  ignored
- RDATA  in  64  read data
- RRESP  in  2  read response
- RLAST  in  1  ignored (single beat)
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready

Behaviour:
- FSM, all outputs registered or decoded from state only; no combinational path from any input to any output.
- States: IDLE, ADDR, DATA, DONE. Reset state is IDLE.
- IDLE: sample pc into ARADDR. Next state is ADDR.
- ADDR:
  - ARVALID=1; ARADDR held stable.
  - On ARVALID&ARREADY go to DATA; otherwise stay in ADDR.
  - ARVALID is never withdrawn before the handshake completes.
- DATA:
  - RREADY=1.
  - On RVALID, capture instr = ARADDR[2] ? RDATA[63:32] : RDATA[31:0] (narrow transfer lane select), then go to DONE.
  - RLAST and RID are not checked.
- DONE: instr_valid=1 for exactly this cycle. Next state is IDLE.
- pc must be updated by the consumer in response to instr_valid; the new pc is sampled in the following IDLE cycle.
- Best-case loop with ARREADY=1 and RVALID=1 immediately: IDLE→ADDR→DATA→DONE, i.e. one instruction every 4 cycles.
- instr holds its last captured value outside DONE.
- Constant AR fields are driven continuously, including during reset.
- Reset values: state=IDLE, ARVALID=0, RREADY=0, instr_valid=0, instr=0, ARADDR=0.
- Reset mid-transaction: synchronous return to IDLE. Any in-flight response is dropped; no instr_valid is emitted for it.
- RRESP≠OKAY: data is passed through unchanged unless the optional feature is enabled.
- A misaligned pc (pc[1:0]≠0) is not flagged; lane select uses ARADDR[2] only.

Optional Feature:
- Macro: AXI_IFETCH_RESP_TRAP_EN.
- Defined: if RRESP≠2'b00 at the R handshake, instr is set to EBREAK_INSTR instead of the RDATA lane. instr_valid timing is unchanged.
- Undefined: RRESP is ignored entirely.

Test Plan:
- Reset hold then release, pc=0x80000000, ARREADY=1, RVALID=1 next cycle, RDATA=0x11111111_00000413 → ARVALID one cycle with ARADDR=0x80000000, ARSIZE=2, ARLEN=0, ARPORT=4; instr_valid pulses with instr=0x00000413 four cycles after reset release.
- pc=0x80000004, same RDATA → instr=0x11111111 (upper lane selected).
- ARREADY held 0 for 5 cycles → ARVALID stays 1 and ARADDR stable; pc changes during the stall do not alter ARADDR; no instr_valid until handshake.
- RVALID delayed 3 cycles after AR handshake → RREADY held 1 throughout; exactly one instr_valid pulse after RVALID.
- rstn=0 asserted while in DATA → next cycle ARVALID=0, RREADY=0, instr_valid=0; a late RVALID produces no instr_valid.
- With AXI_IFETCH_RESP_TRAP_EN defined, RRESP=2'b10 → instr=0x00100073. Without the macro → instr=RDATA lane.

Source files
------------

// File: rtl/axi_ifetch_master.sv
// Single-outstanding AXI4 read master: fetches one 32-bit instruction per pc from a 64-bit bus.
// Optional macro AXI_IFETCH_RESP_TRAP_EN: a non-OKAY RRESP substitutes EBREAK_INSTR for the data.
module axi_ifetch_master #(
    parameter logic [3:0]  AXI_ID       = 4'h0,
    parameter logic [31:0] EBREAK_INSTR = 32'h00100073
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [3:0]  ARID,
    output logic [63:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARLOCK,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPORT,
    output logic [3:0]  ARQOS,
    output logic [3:0]  ARREGION,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] araddr_q, araddr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] lane_data;
    logic        trap;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            araddr_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            instr_q  <= instr_d;
        end
    end

    // Narrow 4-byte transfer on a 64-bit bus: address bit 2 picks the lane.
    assign lane_data = araddr_q[2] ? RDATA[63:32] : RDATA[31:0];

`ifdef AXI_IFETCH_RESP_TRAP_EN
    assign trap = (RRESP != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        instr_d  = instr_q;
        unique case (state_q)
            StIdle: begin
                araddr_d = pc;
                state_d  = StAddr;
            end
            StAddr: begin
                if (ARREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (RVALID) begin
                    instr_d = trap ? EBREAK_INSTR : lane_data;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode the registered state only, so no input reaches an output.
    assign ARVALID     = (state_q == StAddr);
    assign RREADY      = (state_q == StData);
    assign instr_valid = (state_q == StDone);
    assign instr       = instr_q;
    assign ARADDR      = araddr_q;

    assign ARID     = AXI_ID;
    assign ARLEN    = 8'd0;
    assign ARSIZE   = 3'b010;
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'b0000;
    assign ARPORT   = 3'b100;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;

    logic unused_inputs;
    assign unused_inputs = ^{RID, RLAST, RRESP, EBREAK_INSTR};

endmodule

// File: tb/tb_axi_ifetch_master.sv
// Randomized bench for axi_ifetch_master: acts as AXI slave and fetch consumer, checks a
// transaction-level model of lane select, trap substitution, handshake timing and reset.
module tb_axi_ifetch_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] pc = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPORT;
    logic [3:0]  ARQOS;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [3:0]  RID = '0;
    logic [63:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b1;
    logic        RVALID = 1'b0;
    logic        RREADY;

    int n_checks = 0;
    int n_errors = 0;

`ifdef AXI_IFETCH_RESP_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    axi_ifetch_master dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .ARID       (ARID),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARBURST    (ARBURST),
        .ARLOCK     (ARLOCK),
        .ARCACHE    (ARCACHE),
        .ARPORT     (ARPORT),
        .ARQOS      (ARQOS),
        .ARREGION   (ARREGION),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RID        (RID),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RLAST      (RLAST),
        .RVALID     (RVALID),
        .RREADY     (RREADY)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected instruction from the address and beat, written from the bus rules directly.
    function automatic logic [31:0] model_instr(input logic [63:0] addr, input logic [63:0] data,
                                                input logic [1:0] resp);
        if (TrapEn && resp != 2'b00) return 32'h00100073;
        if (((addr / 4) % 2) == 1) return data[63:32];
        return data[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ar_fields(input logic [63:0] exp_addr);
        check_eq("araddr", ARADDR, exp_addr);
        check_eq("arsize", {61'd0, ARSIZE}, 64'd2);
        check_eq("arlen", {56'd0, ARLEN}, 64'd0);
        check_eq("arport", {61'd0, ARPORT}, 64'd4);
        check_eq("arburst", {62'd0, ARBURST}, 64'd1);
        check_eq("arid", {60'd0, ARID}, 64'd0);
    endtask

    // One full fetch; entered with the DUT in IDLE (or already presenting p in ADDR).
    task automatic do_fetch(input logic [63:0] p, input int stall, input int rdly,
                            input logic [63:0] data, input logic [1:0] resp);
        int n;
        logic [31:0] exp;
        exp = model_instr(p, data, resp);
        pc = p;
        ARREADY = 1'b0;
        RVALID = 1'b0;
        n = 0;
        while (!ARVALID && n < 20) begin
            step();
            n++;
        end
        check_eq("arvalid_seen", {63'd0, ARVALID}, 64'd1);
        check_ar_fields(p);
        for (int i = 0; i < stall; i++) begin
            pc = {$urandom, $urandom};
            step();
            check_eq("stall_arvalid", {63'd0, ARVALID}, 64'd1);
            check_eq("stall_araddr", ARADDR, p);
            check_eq("stall_no_valid", {63'd0, instr_valid}, 64'd0);
        end
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        check_eq("ar_dropped", {63'd0, ARVALID}, 64'd0);
        check_eq("rready", {63'd0, RREADY}, 64'd1);
        for (int i = 0; i < rdly; i++) begin
            step();
            check_eq("rwait_rready", {63'd0, RREADY}, 64'd1);
            check_eq("rwait_no_valid", {63'd0, instr_valid}, 64'd0);
        end
        RVALID = 1'b1;
        RDATA = data;
        RRESP = resp;
        step();
        RVALID = 1'b0;
        RDATA = {$urandom, $urandom};
        check_eq("instr_valid", {63'd0, instr_valid}, 64'd1);
        check_eq("instr", {32'd0, instr}, {32'd0, exp});
        step();
        check_eq("valid_pulse", {63'd0, instr_valid}, 64'd0);
        check_eq("instr_hold", {32'd0, instr}, {32'd0, exp});
    endtask

    initial begin
        int n;
        int arv_cycles;
        logic [63:0] p;

        // Reset state; constant AR fields must be valid during reset.
        pc = 64'h8000_0000;
        ARREADY = 1'b1;
        RVALID = 1'b1;
        RDATA = 64'h1111_1111_0000_0413;
        RRESP = 2'b00;
        step();
        step();
        check_eq("rst_arvalid", {63'd0, ARVALID}, 64'd0);
        check_eq("rst_rready", {63'd0, RREADY}, 64'd0);
        check_eq("rst_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("rst_instr", {32'd0, instr}, 64'd0);
        check_eq("rst_araddr", ARADDR, 64'd0);
        check_eq("rst_arsize", {61'd0, ARSIZE}, 64'd2);
        check_eq("rst_arport", {61'd0, ARPORT}, 64'd4);

        // Best case from reset release: DONE is the fourth cycle.
        rstn = 1'b1;
        n = 0;
        arv_cycles = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
            if (ARVALID) begin
                arv_cycles++;
                check_ar_fields(64'h8000_0000);
            end
        end
        check_eq("first_latency", n, 3);
        check_eq("arvalid_cycles", arv_cycles, 1);
        check_eq("first_instr", {32'd0, instr}, 64'h0000_0413);

        // Steady state: one instruction every 4 cycles, upper lane.
        pc = 64'h8000_0004;
        n = 0;
        step();
        n++;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("loop_period", n, 4);
        check_eq("upper_lane", {32'd0, instr}, 64'h1111_1111);
        ARREADY = 1'b0;
        RVALID = 1'b0;
        step();

        // Directed stall and late data, then error response.
        do_fetch(64'h0000_1000, 5, 3, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00);
        do_fetch(64'h0000_1004, 0, 0, 64'h1234_5678_9ABC_DEF0, 2'b10);

        // Reset while in DATA drops the transaction.
        p = 64'h0000_2008;
        pc = p;
        n = 0;
        while (!ARVALID && n < 20) begin
            step();
            n++;
        end
        check_eq("mid_arvalid", {63'd0, ARVALID}, 64'd1);
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        check_eq("mid_rready", {63'd0, RREADY}, 64'd1);
        rstn = 1'b0;
        step();
        check_eq("mid_rst_arvalid", {63'd0, ARVALID}, 64'd0);
        check_eq("mid_rst_rready", {63'd0, RREADY}, 64'd0);
        check_eq("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("mid_rst_instr", {32'd0, instr}, 64'd0);
        rstn = 1'b1;
        RVALID = 1'b1;
        RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("late_r_no_valid", {63'd0, instr_valid}, 64'd0);
        end
        RVALID = 1'b0;
        do_fetch(p, 0, 1, 64'h0BAD_F00D_0000_0013, 2'b00);

        // Randomized fetches.
        for (int t = 0; t < 40; t++) begin
            p = {$urandom, $urandom} & ~64'd3;
            do_fetch(p, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                     {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
